regfile_bank: RTL and testbench

- Parametrised multi-entry register bank for the CPU datapath; successor of the single-word write-enabled register.
- Provides one synchronous write port with byte enables and two combinational read ports.
- Optional write-to-read bypass and hardwired-zero entry 0.
- A sequential clear engine zeroes the array after reset or on request, with a BUSY flag.
- Sits between decode (read addresses) and writeback (write port).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 32 +++
 rtl/regfile_bank.sv | 111 +++++++++++
 tb/tb_regfile_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_bank register array.
package regfile_pkg;

    typedef enum logic {IDLE, CLEARING} rf_state_t;

    // One byte lane of a byte-enabled write; shared by the write path and the bypass.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       be);
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: busy/zero-entry masking, write bypass, array select.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int M       = 32,
    parameter int A       = 4,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic         busy,
    input  logic [A-1:0] ra,
    input  logic [M-1:0] rd_mem,
    input  logic         wr_acc,
    input  logic [A-1:0] wa,
    input  logic [M-1:0] wr_data,
    output logic [M-1:0] rd
);

    always_comb begin
        rd = '0;
        if (busy) begin
            rd = '0;
        end else if ((ZERO_R0 != 0) && (ra == '0)) begin
            rd = '0;
        end else if ((BYPASS != 0) && wr_acc && (wa == ra)) begin
            rd = wr_data;
        end else begin
            rd = rd_mem;
        end
    end

endmodule

// File: rtl/regfile_bank.sv
// Multi-entry register bank: one byte-enabled write port, two combinational read
// ports, and a sequential clear engine that sweeps the array after reset or on CLR.
//   state    | meaning
//   IDLE     | array usable, writes accepted, reads return data
//   CLEARING | zeroing mem[cnt] each edge, BUSY high, writes dropped
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int M       = 32,
    parameter int N       = 16,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int A      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           WE,
    input  logic [A-1:0]   WA,
    input  logic [M/8-1:0] WBE,
    input  logic [M-1:0]   DATA_IN,
    input  logic [A-1:0]   RA1,
    input  logic [A-1:0]   RA2,
    output logic [M-1:0]   RD1,
    output logic [M-1:0]   RD2,
    input  logic           CLR,
    output logic           BUSY
);

    rf_state_t    state;
    logic         busy_q;
    logic [A-1:0] cnt;
    logic [M-1:0] mem [N];
    logic         wr_acc;
    logic [M-1:0] wr_data;

    assign wr_acc = WE && !busy_q && !CLR && !((ZERO_R0 != 0) && (WA == '0));

    always_comb begin
        wr_data = mem[WA];
        for (int i = 0; i < M/8; i++) begin
            wr_data[8*i +: 8] = byte_merge(mem[WA][8*i +: 8], DATA_IN[8*i +: 8], WBE[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= CLEARING;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (CLR) begin
                        state  <= CLEARING;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEARING: begin
                    // A CLR during the sweep restarts it from entry 0.
                    if (CLR) begin
                        cnt <= '0;
                    end else if (cnt == A'(N-1)) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + A'(1);
                    end
                end
                default: begin
                    state  <= CLEARING;
                    cnt    <= '0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; the clear engine owns initialisation.
    always_ff @(posedge clk) begin
        if (state == CLEARING) begin
            mem[cnt] <= '0;
        end else if (wr_acc) begin
            mem[WA] <= wr_data;
        end
    end

    assign BUSY = busy_q;

    regfile_read_port #(.M(M), .A(A), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) u_rd1 (
        .busy    (busy_q),
        .ra      (RA1),
        .rd_mem  (mem[RA1]),
        .wr_acc  (wr_acc),
        .wa      (WA),
        .wr_data (wr_data),
        .rd      (RD1)
    );

    regfile_read_port #(.M(M), .A(A), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) u_rd2 (
        .busy    (busy_q),
        .ra      (RA2),
        .rd_mem  (mem[RA2]),
        .wr_acc  (wr_acc),
        .wa      (WA),
        .wr_data (wr_data),
        .rd      (RD2)
    );

endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: three configurations driven in lockstep against a reference model.
module tb_regfile_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, clr;
    logic [3:0]  wa, ra1, ra2;
    logic [3:0]  wbe;
    logic [31:0] din;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_z, rd2_z;
    logic        busy_a, busy_b, busy_z;

    always #5 clk = ~clk;

    regfile_bank #(.M(32), .N(16), .BYPASS(1), .ZERO_R0(0)) dut (
        .clk(clk), .reset(reset), .WE(we), .WA(wa), .WBE(wbe), .DATA_IN(din),
        .RA1(ra1), .RA2(ra2), .RD1(rd1_a), .RD2(rd2_a), .CLR(clr), .BUSY(busy_a));

    regfile_bank #(.M(32), .N(16), .BYPASS(0), .ZERO_R0(0)) dut_nb (
        .clk(clk), .reset(reset), .WE(we), .WA(wa), .WBE(wbe), .DATA_IN(din),
        .RA1(ra1), .RA2(ra2), .RD1(rd1_b), .RD2(rd2_b), .CLR(clr), .BUSY(busy_b));

    regfile_bank #(.M(32), .N(16), .BYPASS(1), .ZERO_R0(1)) dut_z (
        .clk(clk), .reset(reset), .WE(we), .WA(wa), .WBE(wbe), .DATA_IN(din),
        .RA1(ra1), .RA2(ra2), .RD1(rd1_z), .RD2(rd2_z), .CLR(clr), .BUSY(busy_z));

    typedef struct {
        logic        busy;
        logic [31:0] a1, a2, b1, b2, z1, z2;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    bit          m_clr;
    logic [3:0]  m_cnt;
    logic [31:0] m0 [16];
    logic [31:0] mz [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic bit acc(input bit zero);
        return we && !m_clr && !clr && !(zero && wa == 4'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input bit byp, input bit zero, input logic [3:0] ra);
        logic [31:0] old;
        if (m_clr) return 32'h0;
        if (zero && ra == 4'd0) return 32'h0;
        old = zero ? mz[ra] : m0[ra];
        if (byp && acc(zero) && wa == ra) return merge(old, din, wbe);
        return old;
    endfunction

    task automatic model_edge();
        bit a0, az;
        a0 = acc(1'b0);
        az = acc(1'b1);
        if (m_clr) begin
            m0[m_cnt] = 32'h0;
            mz[m_cnt] = 32'h0;
            if (clr) m_cnt = 4'd0;
            else if (m_cnt == 4'd15) begin
                m_clr = 1'b0;
                m_cnt = 4'd0;
            end else m_cnt = m_cnt + 4'd1;
        end else if (clr) begin
            m_clr = 1'b1;
            m_cnt = 4'd0;
        end else begin
            if (a0) m0[wa] = merge(m0[wa], din, wbe);
            if (az) mz[wa] = merge(mz[wa], din, wbe);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
    endtask

    task automatic sample(input string tag);
        exp_t e;
        e.busy = m_clr;
        e.a1 = exp_rd(1'b1, 1'b0, ra1);
        e.a2 = exp_rd(1'b1, 1'b0, ra2);
        e.b1 = exp_rd(1'b0, 1'b0, ra1);
        e.b2 = exp_rd(1'b0, 1'b0, ra2);
        e.z1 = exp_rd(1'b1, 1'b1, ra1);
        e.z2 = exp_rd(1'b1, 1'b1, ra2);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk({tag, ".busy"},   32'(busy_a), 32'(e.busy));
        chk({tag, ".busy_nb"}, 32'(busy_b), 32'(e.busy));
        chk({tag, ".busy_z"}, 32'(busy_z), 32'(e.busy));
        chk({tag, ".rd1"},    rd1_a, e.a1);
        chk({tag, ".rd2"},    rd2_a, e.a2);
        chk({tag, ".rd1_nb"}, rd1_b, e.b1);
        chk({tag, ".rd2_nb"}, rd2_b, e.b2);
        chk({tag, ".rd1_z"},  rd1_z, e.z1);
        chk({tag, ".rd2_z"},  rd2_z, e.z2);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i);
            ra2 = 4'(15 - i);
            sample(tag);
        end
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++) begin
            we  = 1'b1;
            wa  = 4'(i);
            wbe = 4'hF;
            din = (32'h1111_1111 * 32'(i)) ^ 32'hA5A5_0000;
            step();
        end
        we = 1'b0;
    endtask

    task automatic wait_sweep(input string tag, output int n);
        n = 0;
        while (busy_a && n < 40) begin
            sample(tag);
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b0;
        we = 1'b0; clr = 1'b0; wa = '0; wbe = '0; din = '0; ra1 = '0; ra2 = '0;
        m_clr = 1'b1;
        m_cnt = 4'd0;
        for (int i = 0; i < 16; i++) begin
            m0[i] = 32'h0;
            mz[i] = 32'h0;
        end

        @(negedge clk);
        sample("in_reset");
        repeat (3) step();
        reset = 1'b1;
        wait_sweep("boot", n);
        chk("boot_sweep_len", 32'(n), 32'd16);
        read_all("boot_zero");

        we = 1'b1; wa = 4'd5; wbe = 4'hF; din = 32'hDEADBEEF; ra1 = 4'd5; ra2 = 4'd4;
        sample("wr1");
        chk("wr1_bypass", rd1_a, 32'hDEADBEEF);
        step();
        wbe = 4'b0010; din = 32'h0000_5500;
        sample("wr2");
        step();
        we = 1'b0;
        sample("wr2_after");
        chk("wr_merge", rd1_b, 32'hDEAD55EF);

        we = 1'b1; wa = 4'd3; wbe = 4'hF; din = 32'h12345678; ra1 = 4'd3; ra2 = 4'd4;
        sample("byp");
        chk("byp_rd1", rd1_a, 32'h12345678);
        chk("nobyp_rd1_old", rd1_b, 32'h0);
        step();
        we = 1'b0;
        sample("byp_next");
        chk("nobyp_rd1_next", rd1_b, 32'h12345678);

        we = 1'b1; wa = 4'd5; wbe = 4'b0001; din = 32'h0000_00AA; ra1 = 4'd5; ra2 = 4'd5;
        sample("byp_part");
        chk("byp_part_rd2", rd2_a, 32'hDEAD55AA);
        step();
        we = 1'b0;

        we = 1'b1; wa = 4'd0; wbe = 4'hF; din = 32'hFFFFFFFF; ra1 = 4'd0; ra2 = 4'd1;
        sample("r0_wr");
        step();
        wa = 4'd1;
        sample("r1_wr");
        step();
        we = 1'b0;
        sample("r0r1");
        chk("zero_r0", rd1_z, 32'h0);
        chk("zero_r1", rd2_z, 32'hFFFFFFFF);

        fill();
        read_all("fill");

        clr = 1'b1; we = 1'b1; wa = 4'd7; din = 32'hCAFEF00D; wbe = 4'hF; ra1 = 4'd7;
        sample("clr_wr");
        step();
        clr = 1'b0;
        n = 0;
        while (busy_a && n < 40) begin
            we  = 1'b1;
            wa  = 4'($urandom_range(0, 15));
            din = $urandom;
            sample("busy_wr");
            step();
            n++;
        end
        chk("clr_sweep_len", 32'(n), 32'd16);
        we = 1'b0;
        read_all("clr_zero");

        fill();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (8) begin
            sample("sweep_a");
            step();
        end
        clr = 1'b1;
        sample("restart");
        step();
        clr = 1'b0;
        wait_sweep("sweep_b", n);
        chk("restart_len", 32'(n), 32'd16);
        read_all("restart_zero");

        fill();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (10) begin
            sample("sweep_c");
            step();
        end
        reset = 1'b0;
        m_clr = 1'b1;
        m_cnt = 4'd0;
        sample("rst_mid");
        repeat (2) step();
        reset = 1'b1;
        wait_sweep("rst_sweep", n);
        chk("rst_sweep_len", 32'(n), 32'd16);
        read_all("rst_zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
